// File: rtl/zx_video_pipe.sv
// zx_video_pipe
// Pixel stage feeding the DVI/TMDS serialiser on the 25 MHz pixel clock.
// Renders the 256x192 ZX Spectrum screen doubled to 512x384 and centred in
// the 640x480 raster, with a border colour and FLASH handling.
//
// Ports:
//   clk_pixel    pixel clock
//   reset        synchronous, active-high reset
//   de/hs/vs     active-video flag and syncs from the timing generator
//   hcnt/vcnt    raster counters, 0 = first active pixel / line
//   border       border colour, GRB
//   video_addr   video RAM byte address
//   video_dout   video RAM data, one clock after video_addr
//   rgb          {R,G,B}, registered, one clock after the raster inputs
//   rgb_de/hs/vs timing flags re-aligned to rgb
//   flash_phase  current FLASH inversion state
//
// Optional build macro ZX_SCANLINE_EN: halves every channel on odd
// picture lines (each doubled source row's second line).

module zx_video_pipe #(
  parameter int         X0         = 64,
  parameter int         Y0         = 48,
  parameter logic [7:0] LVL_NORM   = 8'hD7,
  parameter logic [7:0] LVL_BRIGHT = 8'hFF
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        de,
  input  logic        hs,
  input  logic        vs,
  input  logic [10:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic [2:0]  border,
  output logic [12:0] video_addr,
  input  logic [7:0]  video_dout,
  output logic [23:0] rgb,
  output logic        rgb_de,
  output logic        rgb_hs,
  output logic        rgb_vs,
  output logic        flash_phase
);

  localparam logic [10:0] X0_L  = 11'(X0);
  localparam logic [10:0] X1_L  = 11'(X0 + 512);
  localparam logic [10:0] Y0_L  = 11'(Y0);
  localparam logic [10:0] Y1_L  = 11'(Y0 + 384);
  localparam logic [10:0] FS_L  = 11'(X0 - 16);
  localparam logic [10:0] FE_L  = 11'(X0 + 496);
  localparam logic        X0_ODD = X0_L[0];

  logic [7:0]  bmp_next;
  logic [7:0]  attr_next;
  logic [7:0]  attr_cur;
  logic [7:0]  shift_reg;
  logic [3:0]  frame_cnt;

  logic        in_rows;
  logic        in_pic;
  logic [8:0]  rel_v;
  logic [7:0]  y;
  logic        shift_tick;
  logic        fetch;
  logic [3:0]  phase;
  logic [10:0] hcnt_n;
  logic        fetch_n;
  logic [8:0]  fn_off;
  logic [3:0]  phase_n;
  logic [4:0]  cell_n;
  logic [12:0] bmp_addr;
  logic [12:0] attr_addr;
  logic        frame_start;
  logic        pix_bit;
  logic [2:0]  pix_col;
  logic [7:0]  pix_lvl;
  logic [23:0] rgb_next;

  function automatic logic [23:0] grb_to_rgb(input logic [2:0] grb, input logic [7:0] lvl);
    return {grb[1] ? lvl : 8'h00, grb[2] ? lvl : 8'h00, grb[0] ? lvl : 8'h00};
  endfunction

  assign in_rows = (vcnt >= Y0_L) && (vcnt < Y1_L);
  assign in_pic  = in_rows && (hcnt >= X0_L) && (hcnt < X1_L);
  assign rel_v   = 9'(vcnt - Y0_L);
  assign y       = 8'(rel_v >> 1);

  // Each source pixel lasts two clocks; advance after the second one.
  assign shift_tick = in_pic && (hcnt[0] != X0_ODD);

  assign fetch = in_rows && (hcnt >= FS_L) && (hcnt < FE_L);
  assign phase = 4'(hcnt - FS_L);

  // The address register is loaded one clock ahead so that it already
  // holds the address during the phase-0/phase-2 clocks, which lets the
  // registered RAM return data in time for the phase-1/phase-3 latches.
  assign hcnt_n  = hcnt + 11'd1;
  assign fetch_n = in_rows && (hcnt_n >= FS_L) && (hcnt_n < FE_L);
  assign fn_off  = 9'(hcnt_n - FS_L);
  assign phase_n = fn_off[3:0];
  assign cell_n  = fn_off[8:4];

  assign bmp_addr  = {y[7:6], y[2:0], y[5:3], cell_n};
  assign attr_addr = 13'h1800 + {3'b000, y[7:3], cell_n};

  assign frame_start = (hcnt == 11'd0) && (vcnt == 11'd0);

  assign pix_bit = shift_reg[7] ^ (attr_cur[7] & flash_phase);
  assign pix_col = pix_bit ? attr_cur[2:0] : attr_cur[5:3];
  assign pix_lvl = attr_cur[6] ? LVL_BRIGHT : LVL_NORM;

  always_comb begin
    rgb_next = 24'h000000;
    if (de) begin
      if (in_pic) begin
        rgb_next = grb_to_rgb(pix_col, pix_lvl);
`ifdef ZX_SCANLINE_EN
        if (rel_v[0]) begin
          rgb_next = {1'b0, rgb_next[23:17], 1'b0, rgb_next[15:9], 1'b0, rgb_next[7:1]};
        end
`endif
      end else begin
        rgb_next = grb_to_rgb(border, LVL_NORM);
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb         <= 24'h000000;
      rgb_de      <= 1'b0;
      rgb_hs      <= 1'b0;
      rgb_vs      <= 1'b0;
      video_addr  <= 13'h0000;
      flash_phase <= 1'b0;
      frame_cnt   <= 4'd0;
      shift_reg   <= 8'h00;
      bmp_next    <= 8'h00;
      attr_next   <= 8'h00;
      attr_cur    <= 8'h00;
    end else begin
      rgb    <= rgb_next;
      rgb_de <= de;
      rgb_hs <= hs;
      rgb_vs <= vs;

      if (fetch_n && (phase_n == 4'd0)) begin
        video_addr <= bmp_addr;
      end else if (fetch_n && (phase_n == 4'd2)) begin
        video_addr <= attr_addr;
      end

      if (fetch && (phase == 4'd1)) begin
        bmp_next <= video_dout;
      end
      if (fetch && (phase == 4'd3)) begin
        attr_next <= video_dout;
      end

      // Phase 15 coincides with an odd picture-relative clock; the load of
      // the next cell must win over the shift.
      if (fetch && (phase == 4'd15)) begin
        shift_reg <= bmp_next;
        attr_cur  <= attr_next;
      end else if (shift_tick) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end

      if (frame_start) begin
        frame_cnt <= frame_cnt + 4'd1;
        if (frame_cnt == 4'd15) begin
          flash_phase <= ~flash_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_zx_video_pipe.sv
// Testbench for zx_video_pipe: drives a compressed raster, models the
// video RAM as a registered memory and predicts every output pixel from a
// direct screen-coordinate lookup of that memory.

module tb_zx_video_pipe;

  localparam int X0 = 64;
  localparam int Y0 = 48;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        de;
  logic        hs;
  logic        vs;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic [2:0]  border;
  logic [12:0] video_addr;
  logic [7:0]  video_dout;
  logic [23:0] rgb;
  logic        rgb_de;
  logic        rgb_hs;
  logic        rgb_vs;
  logic        flash_phase;

  logic [7:0]  vram [0:8191];

  int n_checks = 0;
  int n_fail   = 0;
  int model_frames = 0;
  int blank_limit  = 2047;

  logic [27:0] sb_q[$];

  zx_video_pipe dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .de          (de),
    .hs          (hs),
    .vs          (vs),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .border      (border),
    .video_addr  (video_addr),
    .video_dout  (video_dout),
    .rgb         (rgb),
    .rgb_de      (rgb_de),
    .rgb_hs      (rgb_hs),
    .rgb_vs      (rgb_vs),
    .flash_phase (flash_phase)
  );

  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) video_dout <= vram[video_addr];

  function automatic logic [23:0] expand(input logic [2:0] grb, input logic [7:0] lvl);
    return {grb[1] ? lvl : 8'h00, grb[2] ? lvl : 8'h00, grb[0] ? lvl : 8'h00};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one clock of raster input and queues the predicted output.
  task automatic applyStimulus(input logic r, input logic d, input logic h_s, input logic v_s,
                               input logic [2:0] brd, input logic [10:0] h, input logic [10:0] v);
    logic [23:0] e_rgb;
    logic        e_fp;
    logic        ph;
    logic        pic;
    logic        bitv;
    logic [7:0]  y8;
    logic [7:0]  bm;
    logic [7:0]  at;
    logic [12:0] ba;
    logic [12:0] aa;
    int          x;
    int          yi;
    int          c;
    int          off;
    @(negedge clk_pixel);
    reset  = r;
    de     = d;
    hs     = h_s;
    vs     = v_s;
    border = brd;
    hcnt   = h;
    vcnt   = v;
    if (r) begin
      model_frames = 0;
      blank_limit  = 2047;
      sb_q.push_back(28'h0);
    end else begin
      e_rgb = 24'h0;
      ph  = ((model_frames >> 4) & 1) != 0;
      pic = (int'(h) >= X0) && (int'(h) < X0 + 512) && (int'(v) >= Y0) && (int'(v) < Y0 + 384);
      if (d) begin
        if (!pic) begin
          e_rgb = expand(brd, 8'hD7);
        end else if (int'(h) >= blank_limit) begin
          x  = (int'(h) - X0) / 2;
          yi = (int'(v) - Y0) / 2;
          c  = x / 8;
          y8 = 8'(yi);
          ba = {y8[7:6], y8[2:0], y8[5:3], 5'(c)};
          aa = 13'(6144 + (yi / 8) * 32 + c);
          bm = vram[ba];
          at = vram[aa];
          bitv  = bm[7 - (x % 8)] ^ (at[7] & ph);
          e_rgb = expand(bitv ? at[2:0] : at[5:3], at[6] ? 8'hFF : 8'hD7);
`ifdef ZX_SCANLINE_EN
          if (((int'(v) - Y0) % 2) == 1)
            e_rgb = {1'b0, e_rgb[23:17], 1'b0, e_rgb[15:9], 1'b0, e_rgb[7:1]};
`endif
        end
      end
      if (h == 11'd0 && v == 11'd0) model_frames++;
      e_fp = ((model_frames >> 4) & 1) != 0;
      // A cell shows real data once its fetch has run start to finish.
      off = int'(h) - (X0 - 17);
      if ((int'(v) >= Y0) && (int'(v) < Y0 + 384) && off >= 0 && off <= 16 * 31 &&
          (off % 16) == 0 && blank_limit > X0 + off)
        blank_limit = X0 + off;
      sb_q.push_back({e_rgb, d, h_s, v_s, e_fp});
    end
  endtask

  task automatic sampleOutputs();
    @(posedge clk_pixel);
    #2;
  endtask

  task automatic runSegment(input logic [10:0] v, input int h0, input int h1, input bit rnd);
    for (int h = h0; h <= h1; h++) begin
      if (rnd)
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 11'(h), v);
      else
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 11'(h), v);
    end
  endtask

  always @(posedge clk_pixel) begin
    logic [27:0] e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("sb_pixel", {4'h0, rgb, rgb_de, rgb_hs, rgb_vs, flash_phase}, {4'h0, e});
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
    reset = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; border = 3'b000;
    hcnt = 11'd0; vcnt = 11'd0;

    // Reset held with de high
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 11'(X0 + 5), 11'(Y0 + 5));
      sampleOutputs();
      checkOutput("rst_rgb", {8'h0, rgb}, 32'h0);
      checkOutput("rst_de", {31'h0, rgb_de}, 32'h0);
      checkOutput("rst_addr", {19'h0, video_addr}, 32'h0);
      checkOutput("rst_flash", {31'h0, flash_phase}, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 11'd5, 11'd5);
    sampleOutputs();
    checkOutput("post_rst_de1", {31'h0, rgb_de}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 11'd6, 11'd5);
    sampleOutputs();
    checkOutput("post_rst_de0", {31'h0, rgb_de}, 32'h0);

    // Border and blanking
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 11'd10, 11'd10);
    sampleOutputs();
    checkOutput("border_red", {8'h0, rgb}, 32'h00D70000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 11'd10, 11'd10);
    sampleOutputs();
    checkOutput("border_blank", {8'h0, rgb}, 32'h0);

    // Pixel decode: cell 0, line 0, bitmap 0x80, attr 0x47
    vram[13'h0000] = 8'h80;
    vram[13'h1800] = 8'h47;
    for (int h = X0 - 20; h <= X0 + 15; h++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 11'(h), 11'(Y0));
      if (h >= X0) begin
        sampleOutputs();
        checkOutput("decode", {8'h0, rgb}, (h < X0 + 2) ? 32'h00FFFFFF : 32'h0);
      end
    end

    // Random row y=65 with address checks for cell 3
    for (int c = 0; c < 32; c++) begin
      vram[13'h0900 + c] = 8'($urandom);
      vram[13'h1900 + c] = 8'($urandom);
    end
    for (int h = X0 - 20; h <= X0 + 515; h++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 11'(h), 11'(Y0 + 130));
      if (h == X0 + 32) checkOutput("addr_bmp", {19'h0, video_addr}, 32'h0903);
      if (h == X0 + 34) checkOutput("addr_attr", {19'h0, video_addr}, 32'h1903);
    end
    runSegment(11'(Y0 + 131), X0 - 20, X0 + 515, 1'b1);

    // Scanline pair: bitmap 0xFF, attr 0x47
    vram[13'h0000] = 8'hFF;
    vram[13'h1800] = 8'h47;
    for (int l = 0; l < 2; l++) begin
      for (int h = X0 - 20; h <= X0 + 15; h++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 11'(h), 11'(Y0 + l));
        if (h == X0) begin
          sampleOutputs();
`ifdef ZX_SCANLINE_EN
          checkOutput("scan_pix", {8'h0, rgb}, (l == 1) ? 32'h007F7F7F : 32'h00FFFFFF);
`else
          checkOutput("scan_pix", {8'h0, rgb}, 32'h00FFFFFF);
`endif
        end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 11'd10, 11'(Y0 + l));
      sampleOutputs();
      checkOutput("scan_border", {8'h0, rgb}, 32'h00D70000);
    end

    // Flash: reset lands on frame 0's start, so frame k sees k counter ticks
    vram[13'h0000] = 8'h00;
    vram[13'h1800] = 8'hB8;
    for (int k = 0; k <= 32; k++) begin
      applyStimulus(k == 0, 1'b1, 1'b0, 1'b1, 3'b000, 11'd0, 11'd0);
      for (int h = X0 - 20; h <= X0 + 15; h++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 11'(h), 11'(Y0));
        if (h == X0 && (k == 0 || k == 15 || k == 16 || k == 31 || k == 32)) begin
          sampleOutputs();
          checkOutput("flash_rgb", {8'h0, rgb}, (k >= 16 && k < 32) ? 32'h0 : 32'h00D7D7D7);
          checkOutput("flash_phase", {31'h0, flash_phase}, (k >= 16 && k < 32) ? 32'h1 : 32'h0);
        end
      end
    end

    // Reset mid-line on row y=65: cells 0 and 1 go black, cell 2 recovers
    runSegment(11'(Y0 + 130), X0 - 20, X0 + 7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 11'(X0 + 8), 11'(Y0 + 130));
    for (int h = X0 + 9; h <= X0 + 63; h++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 11'(h), 11'(Y0 + 130));
      if (h == X0 + 20) begin
        sampleOutputs();
        checkOutput("midrst_black", {8'h0, rgb}, 32'h0);
      end
    end

    sampleOutputs();
    checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
